// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic array sequencer:
//     - default array dimension and operand-buffer widths
//     - sequencer state encoding
//     - run_len(): number of RUN cycles for an inner dimension K on an NxN grid
//   No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package systolic_pkg;

    localparam int DEF_ARRAY_N = 4;   // PEs per row/column
    localparam int DEF_K_W     = 8;   // width of inner-dimension length K
    localparam int DEF_ADDR_W  = 8;   // operand buffer address width (>= K_W)

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // K reads, plus 2N-1 cycles for the wavefront to reach and leave PE(N-1,N-1).
    function automatic int unsigned run_len(input int unsigned k, input int unsigned n);
        return k + 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_wavefront_gen.sv
// -----------------------------------------------------------------------------
// systolic_wavefront_gen
//   Combinational per-PE accumulate-enable generator. PE(i,j) sees its first
//   operand pair one cycle after the buffer read (read latency) plus i+j cycles
//   of lane skew, and accumulates for K consecutive cycles:
//       acc_en[i*N+j] = (i+j+1 <= c <= i+j+K)
//   Ports:
//     c       in   CNT_W          RUN cycle counter
//     k_len   in   K_W            latched inner dimension K
//     acc_en  out  ARRAY_N^2      per-PE accumulate enable (unregistered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module systolic_wavefront_gen
    import systolic_pkg::*;
#(
    parameter int ARRAY_N = DEF_ARRAY_N,
    parameter int K_W     = DEF_K_W,
    parameter int CNT_W   = DEF_K_W + $clog2(DEF_ARRAY_N) + 2
) (
    input  logic [CNT_W-1:0]           c,
    input  logic [K_W-1:0]             k_len,
    output logic [ARRAY_N*ARRAY_N-1:0] acc_en
);

    logic [CNT_W-1:0] k_ext;
    assign k_ext = CNT_W'(k_len);

    for (genvar i = 0; i < ARRAY_N; i++) begin : g_row
        for (genvar j = 0; j < ARRAY_N; j++) begin : g_col
            localparam logic [CNT_W-1:0] SKEW = CNT_W'(i + j);
            // c > SKEW is the same as c >= i+j+1; CNT_W is wide enough that
            // SKEW + K cannot overflow.
            assign acc_en[i*ARRAY_N+j] = (c > SKEW) && (c <= SKEW + k_ext);
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
//   Sequencer for an ARRAY_N x ARRAY_N output-stationary systolic array.
//   IDLE -> CLEAR (1 cycle accumulator clear) -> RUN (operand reads + diagonal
//   accumulate wavefront) -> DRAIN (rows out over valid/ready) -> DONE -> IDLE.
//   K=0 skips RUN. All outputs are registered from next-state values, so each
//   output describes the state the sequencer is currently in.
//
//   Optional feature: define SYSTOLIC_SEQ_CTRL_PERF_EN to enable a 32-bit
//   saturating job cycle counter on perf_cycles_o (tied to 0 otherwise).
//
//   Ports:
//     clk            in   1          clock
//     rst            in   1          synchronous active-high reset
//     start_i        in   1          start request, sampled only in IDLE
//     k_len_i        in   K_W        inner dimension K, latched with start_i
//     busy_o         out  1          high in every state except IDLE
//     done_o         out  1          one-cycle job-complete pulse
//     acc_clr_o      out  1          accumulator clear to all PEs
//     rd_en_o        out  1          operand buffer read enable
//     rd_addr_o      out  ADDR_W     operand buffer read address
//     acc_en_o       out  N*N        per-PE accumulate enable, bit i*N+j = PE(i,j)
//     out_valid_o    out  1          result row available
//     out_row_o      out  clog2(N)   index of the row being drained
//     out_ready_i    in   1          downstream accepts a row
//     perf_cycles_o  out  32         job cycle count
//   ARRAY_N must be >= 2.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_N = DEF_ARRAY_N,
    parameter int K_W     = DEF_K_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [K_W-1:0]               k_len_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         acc_clr_o,
    output logic                         rd_en_o,
    output logic [ADDR_W-1:0]            rd_addr_o,
    output logic [ARRAY_N*ARRAY_N-1:0]   acc_en_o,
    output logic                         out_valid_o,
    output logic [$clog2(ARRAY_N)-1:0]   out_row_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  perf_cycles_o
);

    localparam int ROW_W = $clog2(ARRAY_N);
    localparam int CNT_W = K_W + $clog2(ARRAY_N) + 2;

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_CLEAR = ST_CLEAR;
    localparam logic [2:0] S_RUN   = ST_RUN;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_DONE  = ST_DONE;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_N - 1);

    logic [2:0]       state_q, state_n;
    logic [CNT_W-1:0] c_q, c_n;
    logic [ROW_W-1:0] r_q, r_n;
    logic [K_W-1:0]   k_q, k_n;
    logic [CNT_W-1:0] last_c;
    logic             run_n;
    logic             rd_hit_n;
    logic [ARRAY_N*ARRAY_N-1:0] wave_n;

    assign last_c = CNT_W'(run_len(32'(k_q), 32'(ARRAY_N)) - 32'd1);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_n = state_q;
        c_n     = c_q;
        r_n     = r_q;
        k_n     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_n = S_CLEAR;
                    k_n     = k_len_i;
                end
            end
            S_CLEAR: begin
                c_n     = '0;
                r_n     = '0;
                state_n = (k_q == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (c_q == last_c) begin
                    state_n = S_DRAIN;
                    r_n     = '0;
                end else begin
                    c_n = c_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_valid_o && out_ready_i) begin
                    if (r_q == LAST_ROW) begin
                        state_n = S_DONE;
                    end else begin
                        r_n = r_q + ROW_W'(1);
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign run_n    = (state_n == S_RUN);
    assign rd_hit_n = run_n && (c_n < CNT_W'(k_n));

    systolic_wavefront_gen #(
        .ARRAY_N (ARRAY_N),
        .K_W     (K_W),
        .CNT_W   (CNT_W)
    ) u_wavefront (
        .c      (c_n),
        .k_len  (k_n),
        .acc_en (wave_n)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            c_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            acc_clr_o   <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            acc_en_o    <= '0;
            out_valid_o <= 1'b0;
            out_row_o   <= '0;
        end else begin
            state_q     <= state_n;
            c_q         <= c_n;
            r_q         <= r_n;
            k_q         <= k_n;
            busy_o      <= (state_n != S_IDLE);
            done_o      <= (state_n == S_DONE);
            acc_clr_o   <= (state_n == S_CLEAR);
            rd_en_o     <= rd_hit_n;
            rd_addr_o   <= rd_hit_n ? ADDR_W'(c_n) : '0;
            acc_en_o    <= run_n ? wave_n : '0;
            out_valid_o <= (state_n == S_DRAIN);
            out_row_o   <= (state_n == S_DRAIN) ? r_n : '0;
        end
    end

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Counts cycles with busy_o high. Loading 1 on start acceptance accounts
    // for the CLEAR cycle, so the value seen during DONE is already final and
    // holds through IDLE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            perf_q <= 32'd1;
        end else if (state_n != S_IDLE && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//   Scoreboard bench for systolic_seq_ctrl (N=4, K_W=8, ADDR_W=8). When a start
//   is accepted, the reference model pushes the expected per-cycle outputs of
//   CLEAR and RUN plus the expected drain row sequence; a negedge monitor pops
//   and compares. Compile with SYSTOLIC_SEQ_CTRL_PERF_EN to check the counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_systolic_seq_ctrl;

    localparam int N      = 4;
    localparam int K_W    = 8;
    localparam int ADDR_W = 8;
    localparam int ROW_W  = 2;
    localparam int NN     = N * N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [K_W-1:0]    k_len_i = '0;
    logic              out_ready_i = 1'b1;
    logic              busy_o, done_o, acc_clr_o, rd_en_o, out_valid_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [NN-1:0]     acc_en_o;
    logic [ROW_W-1:0]  out_row_o;
    logic [31:0]       perf_cycles_o;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(
        .ARRAY_N (N),
        .K_W     (K_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .k_len_i       (k_len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .acc_clr_o     (acc_clr_o),
        .rd_en_o       (rd_en_o),
        .rd_addr_o     (rd_addr_o),
        .acc_en_o      (acc_en_o),
        .out_valid_o   (out_valid_o),
        .out_row_o     (out_row_o),
        .out_ready_i   (out_ready_i),
        .perf_cycles_o (perf_cycles_o)
    );

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              clr;
        logic              rd_en;
        logic [ADDR_W-1:0] addr;
        logic [NN-1:0]     acc;
        logic              valid;
        logic [ROW_W-1:0]  row;
    } obs_t;

    typedef enum {M_IDLE, M_JOB, M_DONE} mphase_e;

    obs_t        cyc_q[$];
    int          row_q[$];
    mphase_e     m_phase = M_IDLE;
    int          m_k = 0;
    int          m_drain = 0;
    logic [31:0] m_perf = '0;
    int          jobs_done = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    int          ready_mode = 0;
    int          bp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy_o;
        o.done  = done_o;
        o.clr   = acc_clr_o;
        o.rd_en = rd_en_o;
        o.addr  = rd_addr_o;
        o.acc   = acc_en_o;
        o.valid = out_valid_o;
        o.row   = out_row_o;
        return o;
    endfunction

    // RUN cycle c: buffer address c is read while c<K; PE(i,j) is working on
    // operand index t = c-1-(i+j) and accumulates while that index is in 0..K-1.
    function automatic obs_t run_obs(input int c, input int k);
        obs_t o;
        o = '0;
        o.busy = 1'b1;
        if (c < k) begin
            o.rd_en = 1'b1;
            o.addr  = ADDR_W'(c);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int t;
                t = c - 1 - (i + j);
                o.acc[i*N+j] = (t >= 0) && (t < k);
            end
        end
        return o;
    endfunction

    task automatic push_job(input int k);
        obs_t o;
        o = '0;
        o.busy = 1'b1;
        o.clr  = 1'b1;
        cyc_q.push_back(o);
        if (k > 0) begin
            for (int c = 0; c < k + 2 * N - 1; c++) cyc_q.push_back(run_obs(c, k));
        end
        for (int r = 0; r < N; r++) row_q.push_back(r);
        m_k     = k;
        m_drain = 0;
        m_phase = M_JOB;
    endtask

    // Monitor and model step, once per cycle away from the active edge.
    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        logic [31:0] exp_perf;
        bit was_idle;
        if (mon_en) begin
            a = sample();
            was_idle = (m_phase == M_IDLE);
            case (m_phase)
                M_IDLE: begin
                    check("idle_outputs", 64'(a), 64'd0);
                    check("idle_perf", 64'(perf_cycles_o), 64'(m_perf));
                end
                M_JOB: begin
                    if (cyc_q.size() > 0) begin
                        e = cyc_q.pop_front();
                        check("clear_run_cycle", 64'(a), 64'(e));
                    end else begin
                        e = '0;
                        e.busy  = 1'b1;
                        e.valid = 1'b1;
                        e.row   = ROW_W'(row_q[0]);
                        check("drain_row", 64'(a), 64'(e));
                        m_drain++;
                        if (out_ready_i) begin
                            void'(row_q.pop_front());
                            if (row_q.size() == 0) m_phase = M_DONE;
                        end
                    end
                end
                default: begin
                    e = '0;
                    e.busy = 1'b1;
                    e.done = 1'b1;
                    check("done_pulse", 64'(a), 64'(e));
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
                    exp_perf = 32'(1 + ((m_k > 0) ? (m_k + 2 * N - 1) : 0) + m_drain + 1);
`else
                    exp_perf = '0;
`endif
                    check("perf_at_done", 64'(perf_cycles_o), 64'(exp_perf));
                    m_perf = exp_perf;
                    jobs_done++;
                    m_phase = M_IDLE;
                end
            endcase
            if (rst) begin
                cyc_q.delete();
                row_q.delete();
                m_phase = M_IDLE;
                m_perf  = '0;
            end else if (was_idle && start_i) begin
                push_job(int'(k_len_i));
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stall row 1 for 5 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready_i = 1'b1;
                1: out_ready_i = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid_o && out_row_o == ROW_W'(1) && bp_cnt < 5) begin
                        out_ready_i = 1'b0;
                        bp_cnt++;
                    end else begin
                        out_ready_i = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_phase != M_IDLE && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (m_phase != M_IDLE) begin
            n_errors++;
            $display("FAIL timeout: job still active after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic run_job(input int k, input int mode);
        wait_idle(2000);
        ready_mode = mode;
        bp_cnt     = 0;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        k_len_i = K_W'(k);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        k_len_i = K_W'($urandom);
        wait_idle(2000);
    endtask

    initial begin
        int target;
        int n;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic job, K=3, always ready.
        run_job(3, 0);
        // K=0: CLEAR straight to DRAIN.
        run_job(0, 0);
        // Backpressure on row 1.
        run_job(5, 2);
        // Minimum non-zero K and maximum K.
        run_job(1, 0);
        run_job(255, 0);

        // start_i held high with k_len_i changing every cycle.
        wait_idle(2000);
        ready_mode = 1;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        target  = jobs_done + 3;
        n       = 0;
        while (jobs_done < target && n < 2000) begin
            k_len_i = K_W'($urandom_range(0, 10));
            @(posedge clk);
            #1;
            n++;
        end
        start_i = 1'b0;
        check("held_start_jobs", 64'(jobs_done >= target), 64'd1);
        wait_idle(2000);

        // Reset at c=4 of RUN, then a fresh job.
        ready_mode = 0;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        k_len_i = K_W'(6);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        run_job(3, 0);

        // Randomized jobs with random backpressure.
        for (int j = 0; j < 6; j++) run_job($urandom_range(0, 12), 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
